// File: rtl/ft_ctrl_pkg.sv
// rtl/ft_ctrl_pkg.sv - shared state encoding and width helper for the ft_control_mc slice
package ft_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RECOVERY,
    WAIT_DONE,
    DONE
  } ft_state_e;

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ft_ctrl_prio_arb.sv
// rtl/ft_ctrl_prio_arb.sv - combinational lowest-index-first picker over the pending vector
module ft_ctrl_prio_arb
  import ft_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int SW = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  output logic [SW-1:0]     grant_idx,
  output logic              grant_valid
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) grant_idx = SW'(i);
    end
    grant_valid = |req;
  end

endmodule

// File: rtl/ft_control_mc.sv
// rtl/ft_control_mc.sv - multi-channel FT recovery controller; FT_CTRL_TIMEOUT_EN builds timeout/retry/fatal logic
module ft_control_mc
  import ft_ctrl_pkg::*;
#(
  parameter int NUM_CH           = 4,
  parameter int RESET_CYCLES     = 2,
  parameter int RECOVERY_TIMEOUT = 64,
  parameter int MAX_RETRIES      = 2,
  localparam int SW = clog2_min1(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [NUM_CH-1:0] error_i,
  input  logic [NUM_CH-1:0] recovery_done_i,
  output logic [NUM_CH-1:0] cores_reset_o,
  output logic [NUM_CH-1:0] recover_o,
  output logic [NUM_CH-1:0] recovering_o,
  output logic              done_o,
  output logic              busy_o,
  output logic [SW-1:0]     sel_o,
  output logic [NUM_CH-1:0] fatal_o
);

  localparam int CW = clog2_min1(RESET_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);

  ft_state_e         state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d, fatal_q, sel_oh, grant_oh, clr_mask, err_mask;
  logic [SW-1:0]     sel_q, grant_idx;
  logic [CW-1:0]     rst_cnt_q;
  logic              grant_valid, grant_take, rst_last, done_hit, timeout_hit, retry_left;

  ft_ctrl_prio_arb #(.NUM_CH(NUM_CH)) u_arb (
    .req         (pending_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign sel_oh     = NUM_CH'(1) << sel_q;
  assign grant_oh   = NUM_CH'(1) << grant_idx;
  assign grant_take = enable_i && (state_q == IDLE) && grant_valid;
  assign rst_last   = (rst_cnt_q == RST_LAST);
  assign done_hit   = |(recovery_done_i & sel_oh);

  // The selected channel's error is masked while busy: its cores may glitch under reset.
  always_comb begin
    clr_mask  = grant_take ? grant_oh : '0;
    err_mask  = (state_q != IDLE) ? sel_oh : '0;
    pending_d = (pending_q & ~clr_mask) | (error_i & ~fatal_q & ~err_mask);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      sel_q     <= '0;
      rst_cnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (grant_take) sel_q <= grant_idx;
      if (enable_i) begin
        if (state_q == RESET) rst_cnt_q <= rst_last ? '0 : rst_cnt_q + CW'(1);
        else                  rst_cnt_q <= '0;
      end
    end
  end

`ifdef FT_CTRL_TIMEOUT_EN
  localparam int TW = clog2_min1(RECOVERY_TIMEOUT);
  localparam int RW = clog2_min1(MAX_RETRIES + 1);

  logic [TW-1:0]     timer_q;
  logic [RW-1:0]     retry_q;
  logic [NUM_CH-1:0] fatal_r;

  assign timeout_hit = (timer_q == TW'(RECOVERY_TIMEOUT - 1));
  assign retry_left  = (retry_q < RW'(MAX_RETRIES));
  assign fatal_q     = fatal_r;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q <= '0;
      retry_q <= '0;
      fatal_r <= '0;
    end else if (enable_i) begin
      case (state_q)
        IDLE: if (grant_valid) begin
          timer_q <= '0;
          retry_q <= '0;
        end
        RECOVERY: timer_q <= '0;
        WAIT_DONE: if (!done_hit) begin
          if (timeout_hit) begin
            if (retry_left) retry_q <= retry_q + RW'(1);
            else            fatal_r <= fatal_r | sel_oh;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign retry_left  = 1'b0;
  assign fatal_q     = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (enable_i) begin
      case (state_q)
        IDLE:      if (grant_valid) state_d = RESET;
        RESET:     if (rst_last) state_d = RECOVERY;
        RECOVERY:  state_d = WAIT_DONE;
        WAIT_DONE: begin
          if (done_hit)         state_d = DONE;
          else if (timeout_hit) state_d = retry_left ? RESET : DONE;
        end
        DONE:      state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cores_reset_o = '0;
    recover_o     = '0;
    recovering_o  = '0;
    done_o        = 1'b0;
    busy_o        = (state_q != IDLE);
    case (state_q)
      RESET:     cores_reset_o = sel_oh;
      RECOVERY: begin
        recover_o    = sel_oh;
        recovering_o = sel_oh;
      end
      WAIT_DONE: recovering_o = sel_oh;
      DONE:      done_o = 1'b1;
      default: ;
    endcase
  end

  assign sel_o   = sel_q;
  assign fatal_o = fatal_q;

endmodule

// File: tb/tb_ft_control_mc.sv
// tb/tb_ft_control_mc.sv - directed self-checking bench for ft_control_mc
module tb_ft_control_mc;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic [3:0] error_i;
  logic [3:0] recovery_done_i;
  logic [3:0] cores_reset_o, recover_o, recovering_o, fatal_o;
  logic       done_o, busy_o;
  logic [1:0] sel_o;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef FT_CTRL_TIMEOUT_EN
  localparam logic [3:0] FATAL_AFTER_T3 = 4'b0001;
`else
  localparam logic [3:0] FATAL_AFTER_T3 = 4'b0000;
`endif

  ft_control_mc #(
    .NUM_CH(4), .RESET_CYCLES(2), .RECOVERY_TIMEOUT(8), .MAX_RETRIES(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .error_i(error_i),
    .recovery_done_i(recovery_done_i), .cores_reset_o(cores_reset_o),
    .recover_o(recover_o), .recovering_o(recovering_o), .done_o(done_o),
    .busy_o(busy_o), .sel_o(sel_o), .fatal_o(fatal_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Runs until done_o (or budget), answering recovery_done on the done_at-th WAIT_DONE cycle.
  task automatic serve(input int done_at, input int ch, input int budget,
                       output int n_reset, output int n_recover, output int n_wait,
                       output logic [1:0] sel_seen, output bit got_done);
    int wait_cnt;
    logic [3:0] ch_oh;
    ch_oh = 4'b0001 << ch;
    n_reset = 0; n_recover = 0; n_wait = 0; wait_cnt = 0;
    sel_seen = 2'b00; got_done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (cores_reset_o != 4'b0) n_reset++;
      if (recover_o != 4'b0) begin
        n_recover++;
        wait_cnt = 0;
      end else if (recovering_o != 4'b0) begin
        n_wait++;
        wait_cnt++;
      end
      recovery_done_i = (done_at != 0 && wait_cnt == done_at) ? ch_oh : 4'b0;
      if (done_o) begin
        got_done = 1'b1;
        sel_seen = sel_o;
        break;
      end
    end
    recovery_done_i = 4'b0;
  endtask

  int nr, nc, nw, frozen;
  logic [1:0] ss;
  bit gd;

  initial begin
    rst_i = 1'b1; enable_i = 1'b1; error_i = 4'b0; recovery_done_i = 4'b0;
    tick(); tick();
    expect_eq("rst_busy", busy_o, 0);
    expect_eq("rst_cores_reset", cores_reset_o, 0);
    expect_eq("rst_recover", recover_o, 0);
    expect_eq("rst_done", done_o, 0);
    expect_eq("rst_sel", sel_o, 0);
    expect_eq("rst_fatal", fatal_o, 0);
    rst_i = 1'b0;
    tick();

    // Test 1: single error pulse on ch2, done on the 5th WAIT_DONE cycle.
    error_i = 4'b0100;
    tick();
    error_i = 4'b0000;
    expect_eq("t1_latch_no_reset", cores_reset_o, 4'b0000);
    tick();
    expect_eq("t1_reset_c1", cores_reset_o, 4'b0100);
    expect_eq("t1_sel", sel_o, 2);
    tick();
    expect_eq("t1_reset_c2", cores_reset_o, 4'b0100);
    tick();
    expect_eq("t1_recover", recover_o, 4'b0100);
    expect_eq("t1_recover_rst_off", cores_reset_o, 4'b0000);
    tick();
    expect_eq("t1_recover_one_cycle", recover_o, 4'b0000);
    expect_eq("t1_recovering", recovering_o, 4'b0100);
    for (int k = 2; k <= 5; k++) begin
      tick();
      expect_eq("t1_wait_no_done", done_o, 0);
    end
    recovery_done_i = 4'b0100;
    tick();
    recovery_done_i = 4'b0000;
    expect_eq("t1_done", done_o, 1);
    expect_eq("t1_fatal", fatal_o, 0);
    tick();
    expect_eq("t1_done_pulse_end", done_o, 0);
    expect_eq("t1_idle", busy_o, 0);

    // Test 2: simultaneous errors on ch1 and ch3, served in ascending order.
    error_i = 4'b1010;
    tick();
    error_i = 4'b0000;
    serve(3, 1, 40, nr, nc, nw, ss, gd);
    expect_eq("t2a_done", gd, 1);
    expect_eq("t2a_sel", ss, 1);
    expect_eq("t2a_resets", nr, 2);
    expect_eq("t2a_recovers", nc, 1);
    tick();
    expect_eq("t2_gap_idle", busy_o, 0);
    serve(3, 3, 40, nr, nc, nw, ss, gd);
    expect_eq("t2b_done", gd, 1);
    expect_eq("t2b_sel", ss, 3);
    tick();

    // Test 3: ch0 never completes recovery.
    error_i = 4'b0001;
    tick();
    error_i = 4'b0000;
`ifdef FT_CTRL_TIMEOUT_EN
    serve(0, 0, 200, nr, nc, nw, ss, gd);
    expect_eq("t3_done", gd, 1);
    expect_eq("t3_resets", nr, 6);
    expect_eq("t3_recovers", nc, 3);
    expect_eq("t3_waits", nw, 24);
    expect_eq("t3_fatal", fatal_o, 4'b0001);
    tick();
    error_i = 4'b0001;
    tick();
    error_i = 4'b0000;
    tick(); tick();
    expect_eq("t3_fatal_ignored", busy_o, 0);
`else
    serve(0, 0, 60, nr, nc, nw, ss, gd);
    expect_eq("t3_no_done", gd, 0);
    expect_eq("t3_recovers", nc, 1);
    expect_eq("t3_still_busy", busy_o, 1);
    expect_eq("t3_fatal", fatal_o, 0);
    recovery_done_i = 4'b0001;
    tick();
    recovery_done_i = 4'b0000;
    expect_eq("t3_late_done", done_o, 1);
    tick();
`endif

    // Test 4: done on the exact timeout cycle wins over retry.
    error_i = 4'b0010;
    tick();
    error_i = 4'b0000;
    serve(8, 1, 60, nr, nc, nw, ss, gd);
    expect_eq("t4_done", gd, 1);
    expect_eq("t4_recovers", nc, 1);
    expect_eq("t4_resets", nr, 2);
    expect_eq("t4_fatal", fatal_o, FATAL_AFTER_T3);
    tick();

    // Test 5: enable low mid-RESET freezes the FSM while ch3's error is latched.
    error_i = 4'b0100;
    tick();
    error_i = 4'b0000;
    tick();
    expect_eq("t5_reset_c1", cores_reset_o, 4'b0100);
    enable_i = 1'b0;
    frozen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) error_i = 4'b1000;
      if (i == 3) error_i = 4'b0000;
      tick();
      if (cores_reset_o == 4'b0100 && recover_o == 4'b0000 && sel_o == 2) frozen++;
    end
    expect_eq("t5_frozen_cycles", frozen, 10);
    enable_i = 1'b1;
    tick();
    expect_eq("t5_reset_c2", cores_reset_o, 4'b0100);
    tick();
    expect_eq("t5_recover", recover_o, 4'b0100);
    serve(2, 2, 40, nr, nc, nw, ss, gd);
    expect_eq("t5_ch2_done", gd, 1);
    expect_eq("t5_ch2_sel", ss, 2);
    serve(2, 3, 40, nr, nc, nw, ss, gd);
    expect_eq("t5_ch3_done", gd, 1);
    expect_eq("t5_ch3_sel", ss, 3);
    expect_eq("t5_ch3_resets", nr, 2);
    tick();

    // Test 6: reset during WAIT_DONE aborts with pending work discarded.
    error_i = 4'b0010;
    tick();
    error_i = 4'b0000;
    tick(); tick(); tick(); tick();
    expect_eq("t6_in_wait", recovering_o, 4'b0010);
    error_i = 4'b0100;
    tick();
    error_i = 4'b0000;
    rst_i = 1'b1;
    tick();
    expect_eq("t6_busy", busy_o, 0);
    expect_eq("t6_cores_reset", cores_reset_o, 0);
    expect_eq("t6_recovering", recovering_o, 0);
    expect_eq("t6_done", done_o, 0);
    expect_eq("t6_sel", sel_o, 0);
    expect_eq("t6_fatal", fatal_o, 0);
    rst_i = 1'b0;
    tick(); tick(); tick();
    expect_eq("t6_pending_cleared", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
